// File: rtl/bounce_pkg.sv
// Shared types and constants for the bouncy push-button emulator.
// Holds the FSM state encoding and the Galois LFSR definition.
package bounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BOUNCE = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DEF_SEED  = 16'hACE1;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advances every clock.
// Reset loads the seed, which the parent guarantees is non-zero.
module lfsr16
  import bounce_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= seed;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/bounce_gen.sv
// Bouncy push-button emulator: turns a clean level change into an
// odd burst of toggles, a stable settle window and a done pulse.
module bounce_gen
  import bounce_pkg::*;
#(
  parameter int          RANDOM     = 1,
  parameter int          BOUNCE_W   = 3,
  parameter int          GAP_W      = 4,
  parameter int          BOUNCE_FIX = 3,
  parameter int          GAP_FIX    = 4,
  parameter int          SETTLE_CYC = 32,
  parameter logic [15:0] SEED       = DEF_SEED
) (
  input  logic src_clk,
  input  logic rst,
  input  logic level_in,
  output logic pb_out,
  output logic busy,
  output logic done
);

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [GAP_W:0]    G_ONE = (GAP_W + 1)'(1);
  localparam logic [BOUNCE_W:0] R_ONE = (BOUNCE_W + 1)'(1);
  localparam logic [SW-1:0]     S_ONE = SW'(1);
  localparam logic [SW-1:0]     S_LD  = SW'(SETTLE_CYC);

  state_t r_state, w_state;
  logic r_pb, w_pb;
  logic r_settled, w_settled;
  logic r_target, w_target;
  logic r_busy, w_busy;
  logic r_done, w_done;
  logic [BOUNCE_W:0] r_rem, w_rem;
  logic [GAP_W:0]    r_gap, w_gap;
  logic [SW-1:0]     r_set, w_set;

  logic [15:0]         w_lfsr;
  logic [BOUNCE_W-1:0] w_n;
  logic [GAP_W:0]      w_gld;
  logic                w_unused;

  lfsr16 u_lfsr (
    .clk  (src_clk),
    .rst  (rst),
    .seed (SEED_EFF),
    .q    (w_lfsr)
  );

  assign w_unused = ^w_lfsr;

  assign w_n = (RANDOM != 0)
    ? w_lfsr[BOUNCE_W-1:0]
    : BOUNCE_W'(BOUNCE_FIX);

  assign w_gld = (RANDOM != 0)
    ? ({1'b0, w_lfsr[GAP_W-1:0]} + G_ONE)
    : (GAP_W + 1)'(GAP_FIX);

  always_ff @(posedge src_clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pb      <= 1'b0;
      r_settled <= 1'b0;
      r_target  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rem     <= '0;
      r_gap     <= '0;
      r_set     <= '0;
    end else begin
      r_state   <= w_state;
      r_pb      <= w_pb;
      r_settled <= w_settled;
      r_target  <= w_target;
      r_busy    <= w_busy;
      r_done    <= w_done;
      r_rem     <= w_rem;
      r_gap     <= w_gap;
      r_set     <= w_set;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_pb      = r_pb;
    w_settled = r_settled;
    w_target  = r_target;
    w_busy    = r_busy;
    w_done    = 1'b0;
    w_rem     = r_rem;
    w_gap     = r_gap;
    w_set     = r_set;
    unique case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        w_pb   = r_settled;
        if (level_in != r_settled) begin
          // First edge goes out immediately; 2n more follow.
          w_target = level_in;
          w_pb     = ~r_settled;
          w_rem    = {w_n, 1'b0};
          w_gap    = w_gld;
          w_busy   = 1'b1;
          w_state  = ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (r_gap == G_ONE) begin
          if (r_rem != '0) begin
            w_pb  = ~r_pb;
            w_rem = r_rem - R_ONE;
            w_gap = w_gld;
          end else begin
            w_set   = S_LD;
            w_state = ST_SETTLE;
          end
        end else begin
          w_gap = r_gap - G_ONE;
        end
      end
      ST_SETTLE: begin
        if (r_set == S_ONE) begin
          w_set     = '0;
          w_settled = r_target;
          w_done    = 1'b1;
          w_busy    = 1'b0;
          w_state   = ST_IDLE;
        end else begin
          w_set = r_set - S_ONE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign pb_out = r_pb;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter RANDOM, default 1: 1 = pseudo-random bounce count and gaps, 0 = fixed (BOUNCE_FIX, GAP_FIX).
REQ-002 SHALL have parameter BOUNCE_W, default 3: width of the bounce-pair count.
REQ-003 SHALL have parameter GAP_W, default 4: gap between toggles spans 1..2^GAP_W cycles.
REQ-004 SHALL have parameters BOUNCE_FIX, default 3, and GAP_FIX, default 4: fixed pair count and gap used when RANDOM=0.
REQ-005 SHALL have parameter SETTLE_CYC, default 32: stable hold time after the last toggle.
REQ-006 SHALL have parameter SEED, default 16'hACE1: LFSR reset value; SEED=0 SHALL be replaced by 16'h0001.
REQ-007 SHALL have port src_clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-009 SHALL have port level_in, input, 1 bit: clean requested button level, synchronous to src_clk.
REQ-010 SHALL have port pb_out, output, 1 bit: emulated bouncy push-button line, registered.
REQ-011 SHALL have port busy, output, 1 bit: high while in BOUNCE or SETTLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when settling completes.

Function
REQ-013 SHALL run a 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, mask 16'hB400) that advances every cycle and never holds 0.
REQ-014 SHALL implement FSM states IDLE, BOUNCE, SETTLE and keep an internal settled level.
REQ-015 In IDLE with level_in == settled: SHALL hold pb_out = settled.
REQ-016 In IDLE with level_in != settled: SHALL latch target = level_in and load n = lfsr[BOUNCE_W-1:0] (RANDOM=1) or BOUNCE_FIX (RANDOM=0).
REQ-017 On that same IDLE cycle: SHALL toggle pb_out, set remaining = 2*n, load gap = lfsr[GAP_W-1:0]+1 (or GAP_FIX), and enter BOUNCE.
REQ-018 In BOUNCE, gap SHALL decrement every cycle.
REQ-019 In BOUNCE, when gap reaches 1 with remaining > 0: SHALL toggle pb_out, decrement remaining, and reload gap.
REQ-020 In BOUNCE, when gap reaches 1 with remaining == 0: SHALL load the settle counter with SETTLE_CYC and enter SETTLE.
REQ-021 Total toggles per event SHALL be 2n+1 (always odd), so pb_out == target on entering SETTLE.
REQ-022 n == 0 SHALL produce a single clean edge followed by one gap and then SETTLE.
REQ-023 In SETTLE, pb_out SHALL stay constant; after SETTLE_CYC cycles: settled := target, done = 1 for exactly one cycle, return to IDLE.
REQ-024 level_in changes during BOUNCE or SETTLE SHALL be ignored; IDLE re-compares, so a reverted request starts a new sequence toward the new level.
REQ-025 Outputs SHALL be registered; first pb_out change SHALL be visible 1 cycle after level_in differs from settled.
REQ-026 busy SHALL be high from the cycle after detection through the last SETTLE cycle; busy and done SHALL both be low in IDLE except on the done cycle.

Reset
REQ-027 rst SHALL asynchronously force pb_out=0, settled=0, target=0, busy=0, done=0, state=IDLE, all counters 0, LFSR=SEED.
REQ-028 Reset asserted mid-BOUNCE or mid-SETTLE SHALL abort the sequence immediately, with no done pulse.
REQ-029 After release with level_in=1, a fresh sequence SHALL start on the first clock edge.

Structure
REQ-030 Package bounce_pkg SHALL hold the state enum, LFSR mask 16'hB400, and default seed.
REQ-031 Sub-module lfsr16 SHALL contain the LFSR (ports: clk, rst, seed, q); the FSM and counters SHALL live in bounce_gen.
REQ-032 Expected RTL size: 150-250 lines.

Verification
REQ-033 Reset: rst high 3 cycles -> pb_out=0, busy=0, done=0, LFSR=16'hACE1.
REQ-034 RANDOM=0, BOUNCE_FIX=3, GAP_FIX=4, SETTLE_CYC=32; level_in 0->1 -> 7 pb_out toggles spaced 4 cycles, final pb_out=1, done once 32 cycles after the final gap, busy high throughout.
REQ-035 RANDOM=0, BOUNCE_FIX=0: level_in 1->0 -> single pb_out edge, done after GAP_FIX+SETTLE_CYC cycles.
REQ-036 level_in pulses 0->1->0 within 10 cycles during BOUNCE -> first sequence completes at 1, then a second sequence settles at 0; exactly two done pulses.
REQ-037 rst asserted at the 3rd toggle -> pb_out=0 without waiting for a clock edge, no done pulse; a restart after release settles correctly.
REQ-038 RANDOM=1, 1000 random level_in changes -> per event: odd toggle count <= 2*7+1, gaps within 1..16, final pb_out == level_in, LFSR never 0.
